// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared definitions for the two-pattern sequence detector and its event
// logger: event-type encoding, the detector's pattern names and the width
// of one logged record ({type, timestamp}).
package seq_det_pkg;

  // Event types carried in a logged record. 2'b00 is never emitted.
  localparam logic [1:0] EVT_0110 = 2'b01;
  localparam logic [1:0] EVT_0111 = 2'b10;
  localparam logic [1:0] EVT_BOTH = 2'b11;

  // Pattern names used by the detector; values line up with the event types.
  typedef enum logic [1:0] {
    PAT_NONE = 2'b00,
    PAT_0110 = 2'b01,
    PAT_0111 = 2'b10
  } pattern_e;

  // Width of one record: 2-bit type followed by the timestamp.
  function automatic int rec_width(input int ts_w);
    return 2 + ts_w;
  endfunction

endpackage

// File: rtl/seq_evt_fifo.sv
// seq_evt_fifo
// Synchronous show-ahead FIFO. dout always shows the entry at the read
// pointer; it is meaningful only while empty is low.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   push, din    : write request and data; accepted when not full, or when
//                  a pop in the same cycle frees a slot
//   pop          : remove head; ignored while empty
//   dout         : head entry
//   full, empty  : occupancy flags
module seq_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bits means full.
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/seq_event_logger.sv
// seq_event_logger
// Turns single-cycle detector pulses into timestamped event records,
// buffers them in a show-ahead FIFO and keeps saturating hit/drop counters.
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   detected_0110, detected_0111 : detector pulses (one record per high cycle)
//   clr_counts                   : synchronous clear of counters and overflow
//   ev_valid, ev_ready           : record output handshake
//   ev_type, ev_ts               : head record payload
//   cnt_0110, cnt_0111, cnt_drop : saturating counters
//   overflow                     : sticky, set on the first dropped record
//
// Handshake: a record transfers at a rising edge where ev_valid && ev_ready.
// While ev_valid is high and ev_ready low, ev_type/ev_ts hold steady;
// ev_ready while ev_valid is low has no effect.
module seq_event_logger
  import seq_det_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             detected_0110,
  input  logic             detected_0111,
  input  logic             clr_counts,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_type,
  output logic [TS_W-1:0]  ev_ts,
  output logic [CNT_W-1:0] cnt_0110,
  output logic [CNT_W-1:0] cnt_0111,
  output logic [CNT_W-1:0] cnt_drop,
  output logic             overflow
);

  localparam int REC_W = rec_width(TS_W);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] cnt_0110_q, cnt_0110_d;
  logic [CNT_W-1:0] cnt_0111_q, cnt_0111_d;
  logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;
  logic             overflow_q, overflow_d;

  logic             any_hit;
  logic [1:0]       evt_type;
  logic             do_pop;
  logic             fifo_push;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] fifo_dout;

  assign any_hit = detected_0110 || detected_0111;

  always_comb begin
    evt_type = EVT_0110;
    case ({detected_0111, detected_0110})
      2'b01:   evt_type = EVT_0110;
      2'b10:   evt_type = EVT_0111;
      2'b11:   evt_type = EVT_BOTH;
      default: evt_type = EVT_0110;  // no push happens in this case
    endcase
  end

  assign ev_valid  = !fifo_empty;
  assign do_pop    = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO only drops
  // when nothing leaves.
  assign fifo_push = any_hit && (!fifo_full || do_pop);
  assign drop      = any_hit && fifo_full && !do_pop;

  seq_evt_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (do_pop),
    .din   ({evt_type, ts_q}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_type  = fifo_dout[REC_W-1 -: 2];
  assign ev_ts    = fifo_dout[TS_W-1:0];
  assign cnt_0110 = cnt_0110_q;
  assign cnt_0111 = cnt_0111_q;
  assign cnt_drop = cnt_drop_q;
  assign overflow = overflow_q;

  // Hit counters count detections, stored or not. Clear wins over an
  // increment in the same cycle.
  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    cnt_0110_d = cnt_0110_q;
    cnt_0111_d = cnt_0111_q;
    cnt_drop_d = cnt_drop_q;
    overflow_d = overflow_q;
    if (clr_counts) begin
      cnt_0110_d = '0;
      cnt_0111_d = '0;
      cnt_drop_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (detected_0110 && (cnt_0110_q != '1)) cnt_0110_d = cnt_0110_q + CNT_W'(1);
      if (detected_0111 && (cnt_0111_q != '1)) cnt_0111_d = cnt_0111_q + CNT_W'(1);
      if (drop && (cnt_drop_q != '1))          cnt_drop_d = cnt_drop_q + CNT_W'(1);
      if (drop)                                overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      cnt_0110_q <= '0;
      cnt_0111_q <= '0;
      cnt_drop_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      cnt_0110_q <= cnt_0110_d;
      cnt_0111_q <= cnt_0111_d;
      cnt_drop_q <= cnt_drop_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_seq_event_logger.sv
// tb_seq_event_logger
// Directed bench for seq_event_logger with DEPTH=4, TS_W=8, CNT_W=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_seq_event_logger;

  localparam int DEPTH = 4;
  localparam int TS_W  = 8;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             detected_0110;
  logic             detected_0111;
  logic             clr_counts;
  logic             ev_valid;
  logic             ev_ready;
  logic [1:0]       ev_type;
  logic [TS_W-1:0]  ev_ts;
  logic [CNT_W-1:0] cnt_0110;
  logic [CNT_W-1:0] cnt_0111;
  logic [CNT_W-1:0] cnt_drop;
  logic             overflow;

  always #5 clk = ~clk;

  seq_event_logger #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .detected_0110 (detected_0110),
    .detected_0111 (detected_0111),
    .clr_counts    (clr_counts),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_type       (ev_type),
    .ev_ts         (ev_ts),
    .cnt_0110      (cnt_0110),
    .cnt_0111      (cnt_0111),
    .cnt_drop      (cnt_drop),
    .overflow      (overflow)
  );

  int tests_run = 0;
  int failed    = 0;
  // Value the DUT timestamp counter holds now, i.e. the ts the next edge samples.
  logic [TS_W-1:0] tb_ts;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    tb_ts = tb_ts + 8'd1;
    #1;
  endtask

  task automatic drive(input logic d0110, input logic d0111, input logic rdy, input logic clr);
    detected_0110 = d0110;
    detected_0111 = d0111;
    ev_ready      = rdy;
    clr_counts    = clr;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tb_ts = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (ev_valid !== 1'b0 || ev_type !== 2'b00 || ev_ts !== 8'd0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL reset_vals: valid=%b type=%b ts=%0d ovf=%b, want 0 0 0 0", ev_valid, ev_type, ev_ts, overflow);
    end
    tests_run++;
    if (cnt_0110 !== 4'd0 || cnt_0111 !== 4'd0 || cnt_drop !== 4'd0) begin
      failed++;
      $display("FAIL reset_cnts: %0d %0d %0d, want 0 0 0", cnt_0110, cnt_0111, cnt_drop);
    end
    // Buffer three records, then reset without a clock edge.
    drive(1, 0, 0, 0);
    repeat (3) tick();
    drive(0, 0, 0, 0);
    tests_run++;
    if (ev_valid !== 1'b1 || cnt_0110 !== 4'd3) begin
      failed++;
      $display("FAIL reset_prefill: valid=%b cnt=%0d, want 1 3", ev_valid, cnt_0110);
    end
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (ev_valid !== 1'b0 || ev_type !== 2'b00 || ev_ts !== 8'd0 || cnt_0110 !== 4'd0) begin
      failed++;
      $display("FAIL reset_async: valid=%b type=%b ts=%0d cnt=%0d, want 0 0 0 0", ev_valid, ev_type, ev_ts, cnt_0110);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tb_ts = '0;
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tests_run++;
    if (ev_valid !== 1'b1 || ev_type !== 2'b10 || ev_ts !== 8'd0) begin
      failed++;
      $display("FAIL reset_first_ts: valid=%b type=%b ts=%0d, want 1 10 0", ev_valid, ev_type, ev_ts);
    end
  endtask

  task automatic test_single();
    apply_reset();
    repeat (5) tick();
    drive(0, 1, 1, 0);
    tick();
    drive(0, 0, 1, 0);
    tests_run++;
    if (ev_valid !== 1'b1 || ev_type !== 2'b10 || ev_ts !== 8'd5) begin
      failed++;
      $display("FAIL single_rec: valid=%b type=%b ts=%0d, want 1 10 5", ev_valid, ev_type, ev_ts);
    end
    tests_run++;
    if (cnt_0111 !== 4'd1 || cnt_0110 !== 4'd0) begin
      failed++;
      $display("FAIL single_cnt: c0111=%0d c0110=%0d, want 1 0", cnt_0111, cnt_0110);
    end
    tick();
    tests_run++;
    if (ev_valid !== 1'b0) begin
      failed++;
      $display("FAIL single_pop: valid=%b, want 0", ev_valid);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    // Pulses sampled at ts 0,2,4,6,8,10; only the first four fit.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0);
      tick();
    end
    tests_run++;
    if (cnt_0110 !== 4'd6 || cnt_drop !== 4'd2 || overflow !== 1'b1) begin
      failed++;
      $display("FAIL ovf_cnts: c0110=%0d drop=%0d ovf=%b, want 6 2 1", cnt_0110, cnt_drop, overflow);
    end
    // Stalled head must not move.
    tests_run++;
    if (ev_valid !== 1'b1 || ev_ts !== 8'd0) begin
      failed++;
      $display("FAIL ovf_stable: valid=%b ts=%0d, want 1 0", ev_valid, ev_ts);
    end
    // Clear counters and overflow; FIFO contents untouched.
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    tests_run++;
    if (cnt_0110 !== 4'd0 || cnt_drop !== 4'd0 || overflow !== 1'b0 || ev_valid !== 1'b1 || ev_ts !== 8'd0) begin
      failed++;
      $display("FAIL ovf_clr: c0110=%0d drop=%0d ovf=%b valid=%b ts=%0d, want 0 0 0 1 0",
               cnt_0110, cnt_drop, overflow, ev_valid, ev_ts);
    end
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ev_valid !== 1'b1 || ev_type !== 2'b01 || ev_ts !== 8'(2 * i)) begin
        failed++;
        $display("FAIL ovf_drain%0d: valid=%b type=%b ts=%0d, want 1 01 %0d", i, ev_valid, ev_type, ev_ts, 2 * i);
      end
      tick();
    end
    tests_run++;
    if (ev_valid !== 1'b0) begin
      failed++;
      $display("FAIL ovf_empty: valid=%b, want 0", ev_valid);
    end
  endtask

  task automatic test_full_pop();
    logic [1:0] exp_type [5];
    logic [7:0] exp_ts   [5];
    exp_type = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    exp_ts   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    apply_reset();
    drive(1, 0, 0, 0);
    repeat (4) tick();
    // Full: push a 0111 record while popping the head.
    drive(0, 1, 1, 0);
    tick();
    drive(0, 0, 1, 0);
    tests_run++;
    if (cnt_drop !== 4'd0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL fullpop_nodrop: drop=%0d ovf=%b, want 0 0", cnt_drop, overflow);
    end
    for (int i = 1; i < 5; i++) begin
      tests_run++;
      if (ev_valid !== 1'b1 || ev_type !== exp_type[i] || ev_ts !== exp_ts[i]) begin
        failed++;
        $display("FAIL fullpop_rec%0d: valid=%b type=%b ts=%0d, want 1 %b %0d",
                 i, ev_valid, ev_type, ev_ts, exp_type[i], exp_ts[i]);
      end
      tick();
    end
    tests_run++;
    if (ev_valid !== 1'b0) begin
      failed++;
      $display("FAIL fullpop_empty: valid=%b, want 0", ev_valid);
    end
  endtask

  task automatic test_both();
    apply_reset();
    tick();
    drive(1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tests_run++;
    if (ev_valid !== 1'b1 || ev_type !== 2'b11 || ev_ts !== 8'd1) begin
      failed++;
      $display("FAIL both_rec: valid=%b type=%b ts=%0d, want 1 11 1", ev_valid, ev_type, ev_ts);
    end
    tests_run++;
    if (cnt_0110 !== 4'd1 || cnt_0111 !== 4'd1) begin
      failed++;
      $display("FAIL both_cnt: c0110=%0d c0111=%0d, want 1 1", cnt_0110, cnt_0111);
    end
    drive(0, 0, 1, 0);
    tick();
    tests_run++;
    if (ev_valid !== 1'b0) begin
      failed++;
      $display("FAIL both_single: valid=%b, want 0 (one record only)", ev_valid);
    end
  endtask

  task automatic test_sat_clear_wrap();
    apply_reset();
    // 17 consecutive hits with the consumer always ready: back-to-back flow.
    drive(1, 0, 1, 0);
    repeat (17) tick();
    tests_run++;
    if (cnt_0110 !== 4'd15 || cnt_drop !== 4'd0) begin
      failed++;
      $display("FAIL sat_cnt: c0110=%0d drop=%0d, want 15 0", cnt_0110, cnt_drop);
    end
    tests_run++;
    if (ev_valid !== 1'b1 || ev_ts !== 8'd16) begin
      failed++;
      $display("FAIL sat_b2b: valid=%b ts=%0d, want 1 16", ev_valid, ev_ts);
    end
    // Hit with clear in the same cycle: not counted, but stored (ts 17).
    drive(1, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0);
    tests_run++;
    if (cnt_0110 !== 4'd0 || ev_valid !== 1'b1 || ev_ts !== 8'd17 || ev_type !== 2'b01) begin
      failed++;
      $display("FAIL sat_clr: c0110=%0d valid=%b ts=%0d type=%b, want 0 1 17 01", cnt_0110, ev_valid, ev_ts, ev_type);
    end
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    while (tb_ts != 8'd255) tick();
    // Pulses sampled at ts 255 and 0.
    drive(1, 0, 0, 0);
    repeat (2) tick();
    drive(0, 0, 0, 0);
    tests_run++;
    if (ev_valid !== 1'b1 || ev_ts !== 8'd255 || cnt_0110 !== 4'd2) begin
      failed++;
      $display("FAIL wrap_first: valid=%b ts=%0d cnt=%0d, want 1 255 2", ev_valid, ev_ts, cnt_0110);
    end
    drive(0, 0, 1, 0);
    tick();
    tests_run++;
    if (ev_valid !== 1'b1 || ev_ts !== 8'd0 || ev_type !== 2'b01) begin
      failed++;
      $display("FAIL wrap_second: valid=%b ts=%0d type=%b, want 1 0 01", ev_valid, ev_ts, ev_type);
    end
    tick();
    tests_run++;
    if (ev_valid !== 1'b0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL wrap_empty: valid=%b ovf=%b, want 0 0", ev_valid, overflow);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tb_ts = '0;
    reset = 1'b1;
    drive(0, 0, 0, 0);
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_both();
    test_sat_clear_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/seq_event_logger.md
# seq_event_logger

Downstream consumer of the two-pattern sequence detector. Captures each single-cycle `detected_0110` / `detected_0111` pulse as a timestamped event record and buffers it in a small FIFO. Records drain through a valid/ready port. Also keeps saturating per-pattern hit counters plus a drop counter for software/status readout.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TS_W`, 8: timestamp width.
- `CNT_W`, 8: width of each hit/drop counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `detected_0110` in 1: detector pulse, pattern 0110.
- `detected_0111` in 1: detector pulse, pattern 0111.
- `clr_counts` in 1: synchronous clear of `cnt_0110`, `cnt_0111`, `cnt_drop`, `overflow`.
- `ev_valid` out 1: FIFO head holds a record.
- `ev_ready` in 1: consumer accepts the head.
- `ev_type` out 2: head event type.
- `ev_ts` out TS_W: head timestamp.
- `cnt_0110` out CNT_W: saturating 0110 hit count.
- `cnt_0111` out CNT_W: saturating 0111 hit count.
- `cnt_drop` out CNT_W: saturating count of records lost to a full FIFO.
- `overflow` out 1: sticky; set on first drop.

## Operation
- **Timestamp:** free-running `ts` counter, TS_W bits, +1 every cycle, wraps from all-ones to 0 with no flag.
- **Event encoding:**
  - 0110 only → `EVT_0110` = 2'b01.
  - 0111 only → `EVT_0111` = 2'b10.
  - Both high in one cycle → one record `EVT_BOTH` = 2'b11, which counts toward both hit counters.
  - Neither high → no record. 2'b00 is never emitted.
- **Record format:** {type, ts}. `ts` is the value the counter holds in the cycle the pulse is sampled, before that edge's increment.
- **Push/pop conditions:**
  - Push when any detect is high and (FIFO not full, or a pop occurs the same cycle).
  - Pop when `ev_valid && ev_ready`.
  - `ev_ready` while empty is ignored.
- **Full FIFO, no pop:** the new record is dropped, `cnt_drop` increments and `overflow` is set. Hit counters still increment; they count detections, not stored records.
- **Counters:** saturate at all-ones and never wrap.
- **`clr_counts`:** zeroes all counters and `overflow` at the next edge. It has priority over an increment in the same cycle, so that cycle's event is not counted. It does not affect the FIFO or `ts`.
- **FIFO:** show-ahead. `ev_type`/`ev_ts` reflect `mem[rd_ptr]` whenever `ev_valid` is high, and are don't-care when low. Pointers carry one extra wrap bit for full/empty detection.

## Timing
- **Reset values:** `ev_valid`=0, `ev_type`=0, `ev_ts`=0, all counters 0, `overflow`=0, `ts`=0, FIFO pointers 0.
- **Reset mid-operation:** asserting `reset` at any time discards buffered records immediately, without waiting for a clock edge.
- **Latency:** a pulse sampled at edge N makes `ev_valid` high, with the record visible, in the cycle after edge N. This is one cycle from an empty FIFO.
- **Counter update:** counters update at the same edge N as the push.
- **Handshake:** a record is removed at the edge where `ev_valid && ev_ready`. The next entry appears in the following cycle; with back-to-back ready, the port sustains one record per cycle.
- **Simultaneous push+pop:**
  - When full: both occur, occupancy stays at DEPTH, no drop.
  - When empty: pop is impossible and push proceeds.
- **Payload stability:** while `ev_valid` is high and `ev_ready` is low, `ev_type`/`ev_ts` remain stable.
- **Detector pulses:** a pulse lasting k cycles produces k records. The logger does no edge detection.

## Structure
- **Package `seq_det_pkg`:**
  - `EVT_0110`, `EVT_0111`, `EVT_BOTH` localparams.
  - Record-width helper (2+TS_W).
  - The detector's pattern names, so that detector and logger share one encoding.
- **Sub-module `seq_evt_fifo`:** synchronous show-ahead FIFO, parameters WIDTH and DEPTH, ports push/pop/din/dout/full/empty, pop-frees-slot-for-push behaviour.
- **Top level:** `seq_event_logger` holds the timestamp counter, encoder, counters and drop logic.

## Test plan
- **Reset:** assert `reset` mid-run with 3 records buffered → outputs return to reset values with no clock edge; after release, first pulse at `ts`=0 yields `ev_ts`=0.
- **Single event:** `detected_0111` high at ts=5, `ev_ready`=1 → next cycle `ev_valid`=1, `ev_type`=2'b10, `ev_ts`=5; `cnt_0111`=1.
- **Backpressure/overflow:** DEPTH=4, `ev_ready`=0, 6 single-cycle 0110 pulses → 4 stored, `cnt_drop`=2, `overflow`=1, `cnt_0110`=6. Then drain with ready=1 → 4 records in order with increasing ts, then `ev_valid`=0.
- **Full with simultaneous pop:** FIFO full, pulse plus `ev_ready`=1 in the same cycle → no drop, occupancy stays 4.
- **Both pulses together:** `detected_0110` and `detected_0111` high together → one record, type 2'b11; `cnt_0110` and `cnt_0111` each +1.
- **Saturation, clear and wrap:** CNT_W=4, 17 hits → `cnt_0110`=15. Pulse with `clr_counts` high in the same cycle → counters 0 (event not counted), but the record is still stored. `ts` wraps 255→0 with no disturbance.
